// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Build option: SUB_BORROW_IN_EN adds a borrow-in port to serial_ripple_subtractor.
package serial_sub_pkg;

    // Control states of the serial subtractor.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default operand and result width.
    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serial_ripple_subtractor_cell.sv
// One-bit full subtractor: d = x - y - bi, with borrow-out bo.
// This is the only arithmetic cell in the serial subtractor.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: computes a - b (LSB first) through one full_subtractor
// cell, with the borrow rippling through a flip-flop. Operands and results move
// through valid/ready handshakes.
// Build option: define SUB_BORROW_IN_EN to add the bin port, which is captured
// with a/b and seeds the borrow flop, giving a - b - bin.
module serial_ripple_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SUB_BORROW_IN_EN
    input  logic             bin,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    state_t            state_reg;
    state_t            state_next;
    logic [WIDTH-1:0]  sa_reg;
    logic [WIDTH-1:0]  sb_reg;
    logic [WIDTH-1:0]  diff_reg;
    logic [CW-1:0]     count_reg;
    logic              borrow_reg;
    logic              a_msb_reg;
    logic              b_msb_reg;
    logic              bout_reg;
    logic              ovf_reg;
    logic              borrow_init;
    logic              cell_d;
    logic              cell_bo;
    logic              last_bit;

`ifdef SUB_BORROW_IN_EN
    assign borrow_init = bin;
`else
    assign borrow_init = 1'b0;
`endif

    assign last_bit = (count_reg == LAST_COUNT);

    // The single arithmetic cell, fed from the low bits of the operand shifters.
    full_subtractor u_cell (
        .x  (sa_reg[0]),
        .y  (sb_reg[0]),
        .bi (borrow_reg),
        .d  (cell_d),
        .bo (cell_bo)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; handshake outputs depend on the state register only.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: capture operands in IDLE, process one bit per clock in RUN,
    // hold the result while DONE waits for the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_reg     <= '0;
            sb_reg     <= '0;
            diff_reg   <= '0;
            count_reg  <= '0;
            borrow_reg <= 1'b0;
            a_msb_reg  <= 1'b0;
            b_msb_reg  <= 1'b0;
            bout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        sa_reg     <= a;
                        sb_reg     <= b;
                        borrow_reg <= borrow_init;
                        count_reg  <= '0;
                        a_msb_reg  <= a[WIDTH-1];
                        b_msb_reg  <= b[WIDTH-1];
                    end
                end
                RUN: begin
                    sa_reg     <= sa_reg >> 1;
                    sb_reg     <= sb_reg >> 1;
                    diff_reg   <= {cell_d, diff_reg[WIDTH-1:1]};
                    borrow_reg <= cell_bo;
                    count_reg  <= count_reg + CW'(1);
                    if (last_bit) begin
                        // Signed overflow: operands of different sign and the
                        // result sign differs from the minuend's sign.
                        bout_reg <= cell_bo;
                        ovf_reg  <= (a_msb_reg != b_msb_reg) & (cell_d != a_msb_reg);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign diff = diff_reg;
    assign bout = bout_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Directed self-checking bench for serial_ripple_subtractor (WIDTH = 4).
// Define SUB_BORROW_IN_EN for both bench and RTL to exercise the borrow-in port.
module tb_serial_ripple_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    serial_ripple_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef SUB_BORROW_IN_EN
        .bin       (bin_in),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus only: issue one operation from a negedge with in_ready high,
    // wait (bounded) for out_valid, sample the result and complete the
    // handshake (out_ready assumed high). lat = -1 on timeout.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                          output logic [W-1:0] d, output logic bo, output logic ov,
                          output int lat, output int acc_cyc);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        bin_in   = bi;
        @(posedge clk);
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        bin_in   = 1'b0;
        lat      = -1;
        d        = '0;
        bo       = 1'b0;
        ov       = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (out_valid) begin
                lat = n;
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
        d  = diff;
        bo = bout;
        ov = ovf;
        if (lat >= 0) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        compared++;
        if ({in_ready, out_valid, diff, bout, ovf} !== {1'b1, 1'b0, 4'h0, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_state: got rdy=%b vld=%b diff=%h bout=%b ovf=%b, need rdy=1 vld=0 diff=0 bout=0 ovf=0",
                     in_ready, out_valid, diff, bout, ovf);
        end
        $display("test_reset: rdy=%b vld=%b diff=%h", in_ready, out_valid, diff);
    endtask

    task automatic test_subtract();
        logic [W-1:0] va [7];
        logic [W-1:0] vb [7];
        logic [W-1:0] ed [7];
        logic         eb [7];
        logic         eo [7];
        logic [W-1:0] d;
        logic         bo, ov;
        int           lat, acc;
        // a, b, expected diff, bout, ovf (signed view: 4-bit two's complement)
        va = '{4'h9, 4'h3, 4'h7, 4'h8, 4'h2, 4'h0, 4'h0};
        vb = '{4'h3, 4'h9, 4'hF, 4'h1, 4'h5, 4'h0, 4'h1};
        ed = '{4'h6, 4'hA, 4'h8, 4'h7, 4'hD, 4'h0, 4'hF};
        eb = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        eo = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            run_op(va[i], vb[i], 1'b0, d, bo, ov, lat, acc);
            compared++;
            if (lat !== W) begin
                mismatched++;
                $display("FAIL sub_latency[%0d]: got %0d cycles, need %0d", i, lat, W);
            end
            compared++;
            if ({d, bo, ov} !== {ed[i], eb[i], eo[i]}) begin
                mismatched++;
                $display("FAIL sub_result[%0d]: %h-%h got diff=%h bout=%b ovf=%b, need diff=%h bout=%b ovf=%b",
                         i, va[i], vb[i], d, bo, ov, ed[i], eb[i], eo[i]);
            end
            $display("test_subtract: %h - %h -> diff=%h bout=%b ovf=%b lat=%0d", va[i], vb[i], d, bo, ov, lat);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] d0;
        logic         b0, o0;
        bit           ok;
        int           n;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 4'hC;
        b         = 4'h5;
        @(posedge clk);
        @(negedge clk);
        // A second offer during RUN must be ignored.
        a  = 4'h1;
        b  = 4'h1;
        ok = 1'b0;
        for (n = 0; n < 20; n++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            compared++;
            if (in_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL bp_run_ready: got in_ready=%b during RUN, need 0", in_ready);
            end
            @(posedge clk);
            @(negedge clk);
        end
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL bp_timeout: got no out_valid within 20 cycles, need out_valid");
        end
        d0 = diff;
        b0 = bout;
        o0 = ovf;
        compared++;
        if ({d0, b0, o0} !== {4'h7, 1'b0, 1'b1}) begin
            mismatched++;
            $display("FAIL bp_result: got diff=%h bout=%b ovf=%b, need diff=7 bout=0 ovf=1", d0, b0, o0);
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            compared++;
            if ({out_valid, in_ready, diff, bout, ovf} !== {1'b1, 1'b0, d0, b0, o0}) begin
                mismatched++;
                $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b diff=%h bout=%b ovf=%b, need vld=1 rdy=0 diff=%h bout=%b ovf=%b",
                         k, out_valid, in_ready, diff, bout, ovf, d0, b0, o0);
            end
        end
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        compared++;
        if ({in_ready, out_valid} !== 2'b10) begin
            mismatched++;
            $display("FAIL bp_release: got rdy=%b vld=%b after handshake, need rdy=1 vld=0", in_ready, out_valid);
        end
        $display("test_backpressure: C - 5 -> diff=%h bout=%b ovf=%b held 5 cycles", d0, b0, o0);
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] d;
        logic         bo, ov;
        int           lat, acc;
        in_valid = 1'b1;
        a        = 4'h9;
        b        = 4'h3;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if ({in_ready, out_valid, diff, bout, ovf} !== {1'b1, 1'b0, 4'h0, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL midrun_reset: got rdy=%b vld=%b diff=%h bout=%b ovf=%b, need rdy=1 vld=0 diff=0 bout=0 ovf=0",
                     in_ready, out_valid, diff, bout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(4'h5, 4'h2, 1'b0, d, bo, ov, lat, acc);
        compared++;
        if ({d, bo, ov} !== {4'h3, 1'b0, 1'b0} || lat !== W) begin
            mismatched++;
            $display("FAIL midrun_next: got diff=%h bout=%b ovf=%b lat=%0d, need diff=3 bout=0 ovf=0 lat=%0d",
                     d, bo, ov, lat, W);
        end
        $display("test_reset_mid_run: after reset 5 - 2 -> diff=%h bout=%b ovf=%b", d, bo, ov);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] d;
        logic         bo, ov;
        int           lat, acc0, acc1;
        run_op(4'hF, 4'h1, 1'b0, d, bo, ov, lat, acc0);
        compared++;
        if ({d, bo, ov} !== {4'hE, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL b2b_first: got diff=%h bout=%b ovf=%b, need diff=e bout=0 ovf=0", d, bo, ov);
        end
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_ready: got in_ready=%b after handshake, need 1", in_ready);
        end
        run_op(4'h0, 4'h1, 1'b0, d, bo, ov, lat, acc1);
        compared++;
        if ({d, bo, ov} !== {4'hF, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL b2b_second: got diff=%h bout=%b ovf=%b, need diff=f bout=1 ovf=0", d, bo, ov);
        end
        compared++;
        if (acc1 - acc0 !== W + 2) begin
            mismatched++;
            $display("FAIL b2b_interval: got %0d cycles, need %0d", acc1 - acc0, W + 2);
        end
        $display("test_back_to_back: issue interval %0d cycles", acc1 - acc0);
    endtask

`ifdef SUB_BORROW_IN_EN
    task automatic test_borrow_in();
        logic [W-1:0] d;
        logic         bo, ov;
        int           lat, acc;
        run_op(4'h5, 4'h2, 1'b1, d, bo, ov, lat, acc);
        compared++;
        if ({d, bo, ov} !== {4'h2, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL bin_5_2: got diff=%h bout=%b ovf=%b, need diff=2 bout=0 ovf=0", d, bo, ov);
        end
        $display("test_borrow_in: 5 - 2 - 1 -> diff=%h bout=%b", d, bo);
        run_op(4'h0, 4'h0, 1'b1, d, bo, ov, lat, acc);
        compared++;
        if ({d, bo, ov} !== {4'hF, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL bin_0_0: got diff=%h bout=%b ovf=%b, need diff=f bout=1 ovf=0", d, bo, ov);
        end
        $display("test_borrow_in: 0 - 0 - 1 -> diff=%h bout=%b", d, bo);
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bin_in    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_subtract();
        test_reset_mid_run();
        test_backpressure();
        test_back_to_back();
`ifdef SUB_BORROW_IN_EN
        test_borrow_in();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running at 100000, need completion");
        $fatal(1, "watchdog expired");
    end

endmodule
